poly_pitch_generator: RTL and testbench

Parametrised multi-voice square-wave tone source; successor to the single-voice pitch generator. Each of `VOICES` channels turns a (note, octave, gate) setting into a 50 % duty square wave derived from the system clock. Settings are written through a per-voice handshake and take effect only on a half-period boundary, so pitch changes never produce runt pulses. A registered voice-count output drives the downstream audio mixer/PWM stage.

---
 rtl/pitch_pkg.sv | 22 ++
 rtl/pitch_voice.sv | 47 ++++
 rtl/poly_pitch_generator.sv | 55 +++++
 tb/tb_poly_pitch_generator.sv | 119 +++++++++++
 4 files changed

// File: rtl/pitch_pkg.sv
// pitch_pkg: note codes, octave limit, half-period table and lookup
package pitch_pkg;
  typedef enum logic [3:0] {
    NOTE_C, NOTE_CS, NOTE_D, NOTE_DS, NOTE_E, NOTE_F,
    NOTE_FS, NOTE_G, NOTE_GS, NOTE_A, NOTE_AS, NOTE_B, NOTE_REST
  } note_t;
  localparam int OCTAVE_MAX = 8;
  typedef logic [11:0][31:0] base_t;
  // Octave 0 runs A0 (27.5 Hz) upward, so C..G# sit above A0 and A..B start at A0.
  function automatic base_t base_half(input int clk_hz);
    base_t b;
    real f;
    for (int n = 0; n < 12; n++) begin
      f = 27.5 * (2.0 ** (real'(n < 9 ? n + 3 : n - 9) / 12.0));
      b[n] = 32'($rtoi(real'(clk_hz) / (2.0 * f) + 0.5));
    end
    return b;
  endfunction
  function automatic logic [31:0] half_of(input base_t tab, input logic [3:0] note, input logic [3:0] oct);
    return (note > 4'(NOTE_B) || oct > 4'(OCTAVE_MAX)) ? '0 : tab[note] >> oct;
  endfunction
endpackage

// File: rtl/pitch_voice.sv
// pitch_voice: one square-wave channel with a one-deep pending slot applied on half-period boundaries
module pitch_voice #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             ready,
  output logic             wave
);
  logic             running, pend_valid, bnd;
  logic [CNT_W-1:0] cnt, half, pend_half;
  assign bnd = running && cnt == '0;
  assign ready = !pend_valid;
  // A zero half means a silent setting; a write landing on a boundary overrides the pending clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      pend_valid <= 1'b0;
      wave <= 1'b0;
      cnt <= '0;
      half <= '0;
      pend_half <= '0;
    end else begin
      if (bnd) begin
        pend_valid <= 1'b0;
        if (pend_valid && pend_half == '0) begin
          running <= 1'b0;
          wave <= 1'b0;
        end else begin
          wave <= ~wave;
          half <= pend_valid ? pend_half : half;
          cnt <= (pend_valid ? pend_half : half) - 1'b1;
        end
      end else if (running) cnt <= cnt - 1'b1;
      if (wr && running) begin
        pend_valid <= 1'b1;
        pend_half <= wr_half;
      end else if (wr && wr_half != '0) begin
        running <= 1'b1;
        half <= wr_half;
        cnt <= wr_half - 1'b1;
      end
    end
  end
endmodule

// File: rtl/poly_pitch_generator.sv
// poly_pitch_generator: VOICES independent square-wave tone channels with a registered voice count
module poly_pitch_generator
  import pitch_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 21,
  parameter int MIX_W  = $clog2(VOICES + 1),
  localparam int VW    = VOICES > 1 ? $clog2(VOICES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [VW-1:0]     wr_voice,
  input  logic [3:0]        wr_note,
  input  logic [3:0]        wr_octave,
  input  logic              wr_gate,
  output logic              wr_ready,
  output logic [VOICES-1:0] wave,
  output logic [MIX_W-1:0]  mix
);
  localparam base_t BASE = base_half(CLK_HZ);
  logic [CNT_W-1:0]    nh;
  logic [VOICES-1:0]   rdy;
  logic [2**VW-1:0]    rdy_p;
  logic [MIX_W-1:0]    pop;
  // Requested half-period; zero encodes rest or gate off.
  always_comb nh = wr_gate ? CNT_W'(half_of(BASE, wr_note, wr_octave)) : '0;
  // Unused voice slots read as not ready so out-of-range selects are refused.
  always_comb begin
    rdy_p = '0;
    rdy_p[VOICES-1:0] = rdy;
  end
  assign wr_ready = rdy_p[wr_voice];
  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    pitch_voice #(.CNT_W(CNT_W)) u_voice (
      .clk,
      .rst,
      .wr(wr_en && wr_ready && wr_voice == VW'(v)),
      .wr_half(nh),
      .ready(rdy[v]),
      .wave(wave[v])
    );
  end
  // Count of sounding outputs.
  always_comb begin
    pop = '0;
    for (int i = 0; i < VOICES; i++) pop = pop + MIX_W'(wave[i]);
  end
  // Registered count, one cycle behind wave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mix <= '0;
    else mix <= pop;
  end
endmodule

// File: tb/tb_poly_pitch_generator.sv
// tb_poly_pitch_generator: directed vectors and timed sequences for poly_pitch_generator
module tb_poly_pitch_generator;
  logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, wr_gate = 1'b0, wr_ready;
  logic [1:0] wr_voice = '0, mix;
  logic [3:0] wr_note = '0, wr_octave = '0;
  logic [2:0] wave;
  int nvec = 0, nerr = 0, n;

  poly_pitch_generator #(.VOICES(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_voice(wr_voice), .wr_note(wr_note),
    .wr_octave(wr_octave), .wr_gate(wr_gate), .wr_ready(wr_ready), .wave(wave), .mix(mix)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic [3:0] n;
    logic [3:0] o;
    logic       g;
    logic       rdy;
  } vec_t;
  vec_t tv[6];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] v, input logic [3:0] nt, input logic [3:0] o, input logic g);
    wr_voice = v; wr_note = nt; wr_octave = o; wr_gate = g; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_change(input int v, input int limit, output int cnt);
    logic old;
    old = wave[v];
    cnt = 0;
    while (wave[v] == old && cnt < limit) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  initial begin
    tv[0] = '{2'd0, 4'd12, 4'd3,  1'b1, 1'b1};
    tv[1] = '{2'd0, 4'd5,  4'd9,  1'b1, 1'b1};
    tv[2] = '{2'd1, 4'd0,  4'd0,  1'b0, 1'b1};
    tv[3] = '{2'd3, 4'd9,  4'd7,  1'b1, 1'b0};
    tv[4] = '{2'd2, 4'd15, 4'd15, 1'b1, 1'b1};
    tv[5] = '{2'd2, 4'd9,  4'd8,  1'b0, 1'b1};
    #1;
    chk("reset wave", wave, 0);
    chk("reset mix", mix, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      wr_voice = 2'(i); #1;
      chk($sformatf("reset ready v%0d", i), wr_ready, i < 3 ? 1 : 0);
    end
    for (int i = 0; i < 6; i++) begin
      wr_voice = tv[i].v; wr_note = tv[i].n; wr_octave = tv[i].o; wr_gate = tv[i].g; wr_en = 1'b1;
      #1 chk($sformatf("vec%0d ready", i), wr_ready, tv[i].rdy);
      @(posedge clk); #1;
      wr_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("vec%0d silent", i), wave, 0);
      chk($sformatf("vec%0d ready after", i), wr_ready, tv[i].rdy);
    end
    wr(2'd0, 4'd9, 4'd7, 1'b1);
    wait_change(0, 20000, n); chk("v0 first rise", n, 7102);
    chk("mix lag at rise", mix, 0);
    @(posedge clk); #1;
    chk("mix after rise", mix, 1);
    wait_change(0, 20000, n); chk("v0 high time", n, 7101);
    wait_change(0, 20000, n); chk("v0 low time", n, 7102);
    wr(2'd1, 4'd9, 4'd6, 1'b1);
    wait_change(1, 20000, n); chk("v1 first rise", n, 14204);
    chk("wave both", wave, 3);
    chk("mix lag both", mix, 1);
    @(posedge clk); #1;
    chk("mix both", mix, 2);
    wait_change(0, 20000, n); chk("v0 unaffected", n, 7100);
    wr(2'd0, 4'd0, 4'd7, 1'b1);
    chk("pending ready", wr_ready, 0);
    wait_change(0, 20000, n); chk("v0 old half kept", n, 7101);
    chk("ready at boundary", wr_ready, 1);
    wait_change(0, 20000, n); chk("v0 new half a", n, 5972);
    wait_change(0, 20000, n); chk("v0 new half b", n, 5972);
    wr(2'd0, 4'd0, 4'd7, 1'b0);
    wait_change(0, 20000, n); chk("v0 stop time", n, 5971);
    chk("v0 stopped", wave[0], 0);
    wait_change(0, 8000, n); chk("v0 stays low", n, 8000);
    chk("v0 ready after stop", wr_ready, 1);
    wr(2'd1, 4'd0, 4'd8, 1'b1);
    chk("v1 pending ready", wr_ready, 0);
    chk("wave before reset", wave, 2);
    chk("mix before reset", mix, 1);
    #2 rst = 1'b1;
    #1;
    chk("async reset wave", wave, 0);
    chk("async reset mix", mix, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("v1 ready after reset", wr_ready, 1);
    wait_change(1, 2000, n); chk("v1 idle after reset", n, 2000);
    chk("wave idle after reset", wave, 0);
    chk("mix idle after reset", mix, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
